mem_arbiter: RTL

Arbitrates the single external async SRAM between the instruction-fetch port (read-only) and the data-memory port (LW/SW/LW_SP/SW_SP/SW_RS, driven by `ram_op`) of the 16-bit pipeline. Runs a multi-cycle SRAM access FSM that generates the `ce_n`, `oe_n` and `we_n` strobes. Holds `stall_if` while fetch is blocked by a data access, and returns read data through registered ready handshakes. Sits between the IF/MEM pipeline stages and the board SRAM pins.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the SRAM arbiter: FSM state encoding,
// grant encoding and small state-decode helpers used by the strobe logic.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int SRAM_ADDR_W_DEF = 18;
  localparam int DATA_W_DEF      = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_DONE  = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_HOLD  = 3'd5,
    ST_RESP     = 3'd6
  } state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  // True in the states where the SRAM output buffers are enabled
  function automatic logic is_read_state(state_t s);
    return (s == ST_RD_WAIT) || (s == ST_RD_DONE);
  endfunction

  // True in the states where the arbiter drives the SRAM data bus
  function automatic logic is_write_state(state_t s);
    return (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and SRAM pin-side signals of the
// arbiter. The slave modport is the arbiter's view; master is the view of
// the pipeline stages plus the board SRAM (or a bench standing in for them).
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SRAM_ADDR_W = SRAM_ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
);

  // instruction-fetch port (read-only)
  logic                   if_req;
  logic [ADDR_W-1:0]      if_addr;
  logic [DATA_W-1:0]      if_rdata;
  logic                   if_ready;

  // data-memory port
  logic                   mem_req;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   mem_ready;

  logic                   stall_if;

  // SRAM pins (the inout is built above this block from dout/din/doe)
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0]      sram_dout;
  logic [DATA_W-1:0]      sram_din;
  logic                   sram_doe;
  logic                   sram_ce_n;
  logic                   sram_oe_n;
  logic                   sram_we_n;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_din,
    output if_rdata, if_ready, mem_rdata, mem_ready, stall_if,
    output sram_addr, sram_dout, sram_doe, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_din,
    input  if_rdata, if_ready, mem_rdata, mem_ready, stall_if,
    input  sram_addr, sram_dout, sram_doe, sram_ce_n, sram_oe_n, sram_we_n
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbiter for the single async SRAM shared by instruction fetch and data
// memory. Data accesses win ties, except that a data grant is never given
// twice in a row while a fetch is waiting. Each access runs a fixed-length
// strobe sequence; every SRAM strobe, the address/data, ready pulses and
// read data are registered so the pins are glitch-free.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SRAM_ADDR_W = SRAM_ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic            clk_50MHz,
  input  logic            rst,
  mem_arbiter_if.slave    bus
);

  state_t            state;
  state_t            next_state;
  grant_t            grant;        // current grant; doubles as last-grant
  grant_t            next_grant;
  logic              accept;
  logic [ADDR_W-1:0] req_addr;

  // Next-state and arbitration decision; new work is only taken in IDLE
  always_comb begin
    next_state = state;
    next_grant = grant;
    accept     = 1'b0;
    req_addr   = bus.mem_addr;
    unique case (state)
      ST_IDLE: begin
        if (bus.if_req && (grant == GRANT_MEM || !bus.mem_req)) begin
          accept     = 1'b1;
          next_grant = GRANT_IF;
          req_addr   = bus.if_addr;
          next_state = ST_RD_WAIT;      // fetches are always reads
        end else if (bus.mem_req) begin
          accept     = 1'b1;
          next_grant = GRANT_MEM;
          req_addr   = bus.mem_addr;
          next_state = bus.mem_we ? ST_WR_SETUP : ST_RD_WAIT;
        end
      end
      ST_RD_WAIT:  next_state = ST_RD_DONE;
      ST_RD_DONE:  next_state = ST_RESP;
      ST_WR_SETUP: next_state = ST_WR_PULSE;
      ST_WR_PULSE: next_state = ST_WR_HOLD;
      ST_WR_HOLD:  next_state = ST_RESP;
      ST_RESP:     next_state = ST_IDLE;  // requests seen here are ignored
      default:     next_state = ST_IDLE;
    endcase
  end

  // State and grant registers; an async reset drops any access in flight
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      grant <= GRANT_IF;
    end else begin
      state <= next_state;
      grant <= next_grant;
    end
  end

  // Registered pin and handshake outputs, decoded from the upcoming state so
  // the strobes line up exactly with the FSM state they belong to
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      bus.sram_ce_n <= 1'b1;
      bus.sram_oe_n <= 1'b1;
      bus.sram_we_n <= 1'b1;
      bus.sram_doe  <= 1'b0;
      bus.sram_addr <= '0;
      bus.sram_dout <= '0;
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.if_rdata  <= '0;
      bus.mem_rdata <= '0;
    end else begin
      bus.sram_ce_n <= !(is_read_state(next_state) || is_write_state(next_state));
      bus.sram_oe_n <= !is_read_state(next_state);
      bus.sram_we_n <= (next_state != ST_WR_PULSE);
      bus.sram_doe  <= is_write_state(next_state);
      bus.if_ready  <= (next_state == ST_RESP) && (grant == GRANT_IF);
      bus.mem_ready <= (next_state == ST_RESP) && (grant == GRANT_MEM);
      // address and write data are latched once and held for the whole access
      if (accept) begin
        bus.sram_addr <= {{(SRAM_ADDR_W-ADDR_W){1'b0}}, req_addr};
        if (next_grant == GRANT_MEM) begin
          bus.sram_dout <= bus.mem_wdata;
        end
      end
      // read data is sampled on the RD_DONE -> RESP edge into the owner's port
      if (state == ST_RD_DONE) begin
        if (grant == GRANT_IF) begin
          bus.if_rdata <= bus.sram_din;
        end else begin
          bus.mem_rdata <= bus.sram_din;
        end
      end
    end
  end

  // Fetch stalls while its request is outstanding
  assign bus.stall_if = bus.if_req & ~bus.if_ready;

endmodule
